// File: rtl/bmd_256_echo_pkg.sv
// Shared types and width defaults for the echo stamp reader.
package bmd_256_echo_pkg;

    localparam int STAMP_W_DEF = 64;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } echo_state_t;

endpackage

// File: rtl/bmd_256_echo_stamp_reader.sv
// Pops arrival stamps from an external FIFO, computes the wait delta and hands
// each stamp to the TX builder until target_count echoes have been accepted.
module bmd_256_echo_stamp_reader
    import bmd_256_echo_pkg::*;
#(
    parameter int STAMP_W = STAMP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic [CNT_W-1:0]   target_count,
    input  logic [STAMP_W-1:0] waiting_counter,
    input  logic [STAMP_W-1:0] fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic [STAMP_W-1:0] tx_stamp,
    output logic [STAMP_W-1:0] tx_delta,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [CNT_W-1:0]   tx_sent_cnt,
    output logic               echo_done
);

    echo_state_t      state, state_nx;
    logic             rd_en_nx, valid_nx, done_nx;
    logic             capture, cnt_inc, cnt_clr;
    logic [CNT_W-1:0] cnt_plus;

    assign cnt_plus = tx_sent_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            fifo_rd_en  <= 1'b0;
            tx_valid    <= 1'b0;
            echo_done   <= 1'b0;
            tx_sent_cnt <= '0;
            tx_stamp    <= '0;
            tx_delta    <= '0;
        end else begin
            state      <= state_nx;
            fifo_rd_en <= rd_en_nx;
            tx_valid   <= valid_nx;
            echo_done  <= done_nx;
            if (cnt_clr)
                tx_sent_cnt <= '0;
            else if (cnt_inc)
                tx_sent_cnt <= cnt_plus;
            if (capture) begin
                tx_stamp <= fifo_dout;
                tx_delta <= waiting_counter - fifo_dout;
            end
        end
    end

    // The target check in IDLE runs before any read, so the count cannot overshoot.
    always_comb begin
        state_nx = state;
        rd_en_nx = 1'b0;
        valid_nx = tx_valid;
        done_nx  = echo_done;
        capture  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (!trigger) begin
                    cnt_clr = 1'b1;
                end else if (tx_sent_cnt == target_count) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else if (!fifo_empty) begin
                    rd_en_nx = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                capture  = 1'b1;
                valid_nx = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                // Trigger is ignored here: a stamp in flight always completes.
                if (tx_ready) begin
                    valid_nx = 1'b0;
                    cnt_inc  = 1'b1;
                    if (cnt_plus == target_count) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DONE: begin
                if (!trigger) begin
                    cnt_clr  = 1'b1;
                    done_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
